adder_operand_packer: RTL and testbench

//  Upstream feeder for the 100-bit ripple-carry adder stage.

---
 rtl/adder_operand_packer.sv | 130 +++++++++++++
 tb/tb_adder_operand_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_packer.sv
// Packs two OP_W-bit operands from a BEAT_W-bit valid/ready stream (A first, LS beat first)
// and presents a/b/cin to the adder. Optional carry-in capture: define ADDER_PACKER_CIN_EN.
module adder_operand_packer #(
   parameter int OP_W   = 100,
   parameter int BEAT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BEAT_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_cin,
   output logic [OP_W-1:0]   a,
   output logic [OP_W-1:0]   b,
   output logic              cin,
   output logic              op_valid,
   input  logic              op_ready
);

   localparam int NBEATS = (OP_W + BEAT_W - 1) / BEAT_W;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] beat_cnt_reg;
   logic [OP_W-1:0]  a_reg;
   logic [OP_W-1:0]  b_reg;
   logic [OP_W-1:0]  a_next;
   logic [OP_W-1:0]  b_next;
   logic             cin_reg;
   logic             op_valid_reg;
   logic             xfer;
   logic             last_beat;

   assign in_ready  = rst_n && (state_reg != PRESENT);
   assign xfer      = in_valid && in_ready;
   assign last_beat = (beat_cnt_reg == LAST_BEAT);

   // One lane per beat; the top lane is narrower when OP_W is not a multiple of BEAT_W,
   // so the excess in_data bits simply have no destination.
   generate
      for (genvar gi = 0; gi < NBEATS; gi++) begin : g_lane
         localparam int LO = gi * BEAT_W;
         localparam int LW = ((OP_W - LO) < BEAT_W) ? (OP_W - LO) : BEAT_W;
         logic hit_a;
         logic hit_b;
         assign hit_a = xfer && (state_reg == LOAD_A) && (beat_cnt_reg == CNT_W'(gi));
         assign hit_b = xfer && (state_reg == LOAD_B) && (beat_cnt_reg == CNT_W'(gi));
         assign a_next[LO +: LW] = hit_a ? in_data[LW-1:0] : a_reg[LO +: LW];
         assign b_next[LO +: LW] = hit_b ? in_data[LW-1:0] : b_reg[LO +: LW];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= LOAD_A;
         beat_cnt_reg <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         op_valid_reg <= 1'b0;
      end else begin
         a_reg <= a_next;
         b_reg <= b_next;
         case (state_reg)
            LOAD_A: begin
               if (xfer) begin
                  if (last_beat) begin
                     beat_cnt_reg <= '0;
                     state_reg    <= LOAD_B;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  if (last_beat) begin
                     beat_cnt_reg <= '0;
                     state_reg    <= PRESENT;
                     op_valid_reg <= 1'b1;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  end
               end
            end
            PRESENT: begin
               if (op_ready) begin
                  state_reg    <= LOAD_A;
                  op_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg    <= LOAD_A;
               beat_cnt_reg <= '0;
               op_valid_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADDER_PACKER_CIN_EN
   // Carry-in rides on the first A beat and is held for the whole operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cin_reg <= 1'b0;
      end else if (xfer && (state_reg == LOAD_A) && (beat_cnt_reg == '0)) begin
         cin_reg <= in_cin;
      end
   end
`else
   logic unused_cin;
   assign unused_cin = in_cin;

   always_ff @(posedge clk) begin
      cin_reg <= 1'b0;
   end
`endif

   assign a        = a_reg;
   assign b        = b_reg;
   assign cin      = cin_reg;
   assign op_valid = op_valid_reg;

endmodule

// File: tb/tb_adder_operand_packer.sv
// Directed bench for adder_operand_packer at OP_W=100, BEAT_W=32.
// Expected cin follows ADDER_PACKER_CIN_EN.
module tb_adder_operand_packer;

   localparam int OP_W   = 100;
   localparam int BEAT_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [BEAT_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              in_cin;
   logic [OP_W-1:0]   a;
   logic [OP_W-1:0]   b;
   logic              cin;
   logic              op_valid;
   logic              op_ready;

   int checks = 0;
   int errors = 0;

   logic [BEAT_W-1:0] vec [0:7];
   logic              cin_first;

`ifdef ADDER_PACKER_CIN_EN
   localparam logic CIN_EXP = 1'b1;
`else
   localparam logic CIN_EXP = 1'b0;
`endif

   adder_operand_packer #(.OP_W(OP_W), .BEAT_W(BEAT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_cin   (in_cin),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .op_valid (op_valid),
      .op_ready (op_ready)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives the 8 beats in vec[] with 'gaps' idle cycles after each beat except the last.
   // in_valid is left high after the final beat.
   task automatic feed(input int gaps);
      for (int i = 0; i < 8; i++) begin
         in_data  = vec[i];
         in_valid = 1'b1;
         in_cin   = (i == 0) ? cin_first : 1'b0;
         tick();
         if (i < 7) begin
            for (int g = 0; g < gaps; g++) begin
               in_valid = 1'b0;
               in_data  = 32'hFFFF_FFFF;
               in_cin   = 1'b1;
               tick();
            end
         end
      end
      in_cin = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; in_cin = 1'b0;
      op_ready = 1'b0; cin_first = 1'b0;
      tick(); tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++;
      if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
      checks++;
      if (a !== '0 || b !== '0) begin errors++; $display("FAIL reset_ab got a=%h b=%h want 0", a, b); end
      checks++;
      if (cin !== 1'b0) begin errors++; $display("FAIL reset_cin got %b want 0", cin); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
      $display("reset: in_ready=%b op_valid=%b", in_ready, op_valid);
   endtask

   task automatic test_basic;
      vec[0] = 32'hFFFF_FFFF; vec[1] = 32'hFFFF_FFFF; vec[2] = 32'hFFFF_FFFF; vec[3] = 32'h0000_000F;
      vec[4] = 32'h1; vec[5] = 32'h0; vec[6] = 32'h0; vec[7] = 32'h0;
      op_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = vec[i]; in_valid = 1'b1; tick();
      end
      checks++;
      if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", op_valid); end
      in_data = vec[7]; tick();
      in_valid = 1'b0;
      checks++;
      if (op_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL basic_present got op_valid=%b in_ready=%b want 1/0", op_valid, in_ready);
      end
      checks++;
      if (a !== {OP_W{1'b1}}) begin errors++; $display("FAIL basic_a got %h want %h", a, {OP_W{1'b1}}); end
      checks++;
      if (b !== 100'd1) begin errors++; $display("FAIL basic_b got %h want 1", b); end
      $display("basic: a=%h b=%h op_valid=%b", a, b, op_valid);
      tick();
      checks++;
      if (op_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL basic_release got op_valid=%b in_ready=%b want 0/1", op_valid, in_ready);
      end
   endtask

   task automatic test_backpressure;
      logic [OP_W-1:0] ea;
      logic [OP_W-1:0] eb;
      ea = 100'h4_33333333_22222222_11111111;
      eb = 100'h8_77777777_66666666_55555555;
      vec[0] = 32'h1111_1111; vec[1] = 32'h2222_2222; vec[2] = 32'h3333_3333; vec[3] = 32'h0000_0004;
      vec[4] = 32'h5555_5555; vec[5] = 32'h6666_6666; vec[6] = 32'h7777_7777; vec[7] = 32'h0000_0008;
      op_ready = 1'b0;
      feed(0);
      in_data = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (op_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_ctrl cyc %0d got op_valid=%b in_ready=%b want 1/0", c, op_valid, in_ready);
         end
         checks++;
         if (a !== ea || b !== eb) begin
            errors++; $display("FAIL hold_ab cyc %0d got a=%h b=%h want a=%h b=%h", c, a, b, ea, eb);
         end
         tick();
      end
      op_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (op_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", op_valid); end
      $display("backpressure: a=%h b=%h", a, b);
   endtask

   task automatic test_truncation;
      vec[0] = 32'h0; vec[1] = 32'h0; vec[2] = 32'h0; vec[3] = 32'hFFFF_FFF5;
      vec[4] = 32'h0; vec[5] = 32'h0; vec[6] = 32'h0; vec[7] = 32'hFFFF_FFF0;
      op_ready = 1'b1;
      feed(0);
      in_valid = 1'b0;
      checks++;
      if (op_valid !== 1'b1) begin errors++; $display("FAIL trunc_valid got %b want 1", op_valid); end
      checks++;
      if (a !== 100'h5_00000000_00000000_00000000) begin
         errors++; $display("FAIL trunc_a got %h want 5000000000000000000000000", a);
      end
      checks++;
      if (b !== '0) begin errors++; $display("FAIL trunc_b got %h want 0", b); end
      $display("truncation: a=%h b=%h", a, b);
      tick();
   endtask

   task automatic test_gaps;
      logic [OP_W-1:0] ea;
      logic [OP_W-1:0] eb;
      ea = 100'h6_FEDCBA98_01234567_89ABCDEF;
      eb = 100'hA_13579BDF_F0F0F0F0_0F0F0F0F;
      vec[0] = 32'h89AB_CDEF; vec[1] = 32'h0123_4567; vec[2] = 32'hFEDC_BA98; vec[3] = 32'h0000_0006;
      vec[4] = 32'h0F0F_0F0F; vec[5] = 32'hF0F0_F0F0; vec[6] = 32'h1357_9BDF; vec[7] = 32'h0000_000A;
      op_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = vec[i]; in_valid = 1'b1; tick();
         if (i < 7) begin
            in_valid = 1'b0; in_data = 32'hFFFF_FFFF;
            tick(); tick();
            checks++;
            if (op_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid beat %0d got %b want 0", i, op_valid); end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (op_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid got %b want 1", op_valid); end
      checks++;
      if (a !== ea || b !== eb) begin
         errors++; $display("FAIL gaps_ab got a=%h b=%h want a=%h b=%h", a, b, ea, eb);
      end
      $display("gaps: a=%h b=%h", a, b);
      tick();
   endtask

   task automatic test_reset_mid;
      logic [OP_W-1:0] ea;
      logic [OP_W-1:0] eb;
      ea = 100'hD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      eb = 100'hE_00000033_00000022_00000011;
      op_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h0000_0001 + 32'(i); in_valid = 1'b1; tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      checks++;
      if (op_valid !== 1'b0 || a !== '0 || b !== '0) begin
         errors++; $display("FAIL midrst_clear got op_valid=%b a=%h b=%h want 0/0/0", op_valid, a, b);
      end
      rst_n = 1'b1;
      vec[0] = 32'hAAAA_AAAA; vec[1] = 32'hBBBB_BBBB; vec[2] = 32'hCCCC_CCCC; vec[3] = 32'h0000_000D;
      vec[4] = 32'h0000_0011; vec[5] = 32'h0000_0022; vec[6] = 32'h0000_0033; vec[7] = 32'h0000_000E;
      feed(0);
      in_valid = 1'b0;
      checks++;
      if (op_valid !== 1'b1 || a !== ea || b !== eb) begin
         errors++; $display("FAIL midrst_op got op_valid=%b a=%h b=%h want 1 a=%h b=%h", op_valid, a, b, ea, eb);
      end
      $display("reset_mid: a=%h b=%h", a, b);
      tick();
   endtask

   task automatic test_cin;
      vec[0] = 32'h0000_0010; vec[1] = 32'h0; vec[2] = 32'h0; vec[3] = 32'h0;
      vec[4] = 32'h0000_0020; vec[5] = 32'h0; vec[6] = 32'h0; vec[7] = 32'h0;
      op_ready = 1'b0;
      cin_first = 1'b1;
      feed(0);
      in_valid = 1'b0;
      cin_first = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (op_valid !== 1'b1 || cin !== CIN_EXP) begin
            errors++; $display("FAIL cin cyc %0d got op_valid=%b cin=%b want 1/%b", c, op_valid, cin, CIN_EXP);
         end
         tick();
      end
      checks++;
      if (a !== 100'h10 || b !== 100'h20) begin
         errors++; $display("FAIL cin_ab got a=%h b=%h want 10/20", a, b);
      end
      $display("cin: cin=%b a=%h b=%h", cin, a, b);
      op_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_truncation();
      test_gaps();
      test_reset_mid();
      test_cin();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
